// File: rtl/thermo_pkg.sv
// Shared thermostat definitions: FSM state codes, actuator command codes, temperature width.
// The manor controller imports this package as well.
package thermo_pkg;
    localparam int TEMP_W = 6;
    localparam int PRE_W  = 8;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2,
        LEAK = 2'd3
    } state_e;

    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_HEAT = 2'b01;
    localparam logic [1:0] LED_COOL = 2'b10;

    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction
endpackage

// File: rtl/plant_prescaler.sv
// Step prescaler: counts 0..period-1 while enabled and ticks on the last count.
// A clear restarts the count and suppresses the tick for that cycle.
module plant_prescaler
    import thermo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [PRE_W-1:0] period_i,
    output logic             tick_o
);
    logic [PRE_W-1:0] cnt_q;

    // >= so that a count left over from a longer period wraps right away
    assign tick_o = en_i && !clr_i && (cnt_q >= period_i - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (clr_i || tick_o) cnt_q <= '0;
            else                 cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/room_thermal_plant.sv
// Simulated room for closed-loop thermostat tests: integrates the heat/cool command and window
// state into a 6-bit room temperature, one degree per prescaler period.
module room_thermal_plant
    import thermo_pkg::*;
#(
    parameter int T_INIT    = 20,
    parameter int T_EXT     = 10,
    parameter int T_MAX     = 50,
    parameter int T_MIN     = 0,
    parameter int STEP_DIV  = 8,
    parameter int DRIFT_DIV = 32,
    parameter int LEAK_DIV  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        LED,
    input  logic              nWS,
    input  logic              EN,
    output logic [TEMP_W-1:0] RT,
    output logic              RT_VALID,
    output logic [1:0]        MODE
);
    typedef logic [TEMP_W:0] t7_t;
    typedef logic [PRE_W-1:0] per_t;

    localparam int   RT_RST = clamp_int(T_INIT, T_MIN, T_MAX);
    localparam int   LEAK_Q = DRIFT_DIV / LEAK_DIV;
    localparam per_t STEP_P  = per_t'(STEP_DIV);
    localparam per_t STEP_P2 = per_t'(2 * STEP_DIV);
    localparam per_t DRIFT_P = per_t'(DRIFT_DIV);
    localparam per_t LEAK_P  = per_t'((LEAK_Q < 1) ? 1 : LEAK_Q);
    localparam t7_t  TMAX_W  = t7_t'(T_MAX);
    localparam t7_t  TMIN_W  = t7_t'(T_MIN);
    localparam t7_t  TEXT_W  = t7_t'(T_EXT);

    state_e            state_q, state_d;
    logic              nws_q;
    logic [TEMP_W-1:0] rt_q, rt_d;
    logic              vld_q;
    logic              clr, tick;
    per_t              period;
    t7_t               rt_w, up_w, dn_w, sel_w;

    always_comb begin
        state_d = OFF;
        if      (LED == LED_HEAT) state_d = HEAT;
        else if (LED == LED_COOL) state_d = COOL;
        else if (!nWS)            state_d = LEAK;
    end

    // A mode or window change restarts the period rather than finishing a stale one
    assign clr = EN && ((state_d != state_q) || (nWS != nws_q));

    always_comb begin
        case (state_q)
            HEAT, COOL: period = nWS ? STEP_P : STEP_P2;
            LEAK:       period = LEAK_P;
            default:    period = DRIFT_P;
        endcase
    end

    plant_prescaler u_pre (
        .clk      (clk),
        .rst      (rst),
        .en_i     (EN),
        .clr_i    (clr),
        .period_i (period),
        .tick_o   (tick)
    );

    // 7-bit headroom so +1 at 63 cannot wrap; decrement is guarded at the floor
    always_comb begin
        rt_w = {1'b0, rt_q};
        up_w = rt_w + 1'b1;
        dn_w = (rt_w > TMIN_W) ? rt_w - 1'b1 : TMIN_W;
        case (state_q)
            HEAT:    sel_w = up_w;
            COOL:    sel_w = dn_w;
            default: begin
                if      (rt_w < TEXT_W) sel_w = up_w;
                else if (rt_w > TEXT_W) sel_w = dn_w;
                else                    sel_w = rt_w;
            end
        endcase
        if (sel_w > TMAX_W) sel_w = TMAX_W;
        if (sel_w < TMIN_W) sel_w = TMIN_W;
        rt_d = sel_w[TEMP_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            nws_q   <= 1'b1;
            rt_q    <= TEMP_W'(RT_RST);
            vld_q   <= 1'b0;
        end else if (EN) begin
            state_q <= state_d;
            nws_q   <= nWS;
            vld_q   <= tick && (rt_d != rt_q);
            if (tick) rt_q <= rt_d;
        end else begin
            vld_q   <= 1'b0;
        end
    end

    assign RT       = rt_q;
    assign RT_VALID = vld_q;
    assign MODE     = state_q;
endmodule

// File: tb/tb_room_thermal_plant.sv
// Bench for room_thermal_plant: directed scenarios then random command segments, every cycle
// compared against a model that counts elapsed cycles since the last restart of the period.
module tb_room_thermal_plant;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] LED;
    logic       nWS;
    logic       EN;
    logic [5:0] RT;
    logic       RT_VALID;
    logic [1:0] MODE;

    int n_cmp = 0;
    int n_err = 0;

    int m_rt, m_mode, m_prev_nws, m_el, m_vld;

    always #5 clk = ~clk;

    room_thermal_plant dut (
        .clk      (clk),
        .rst      (rst),
        .LED      (LED),
        .nWS      (nWS),
        .EN       (EN),
        .RT       (RT),
        .RT_VALID (RT_VALID),
        .MODE     (MODE)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int want_mode(input int led, input int nws);
        if (led == 1) return 1;
        if (led == 2) return 2;
        if (nws == 0) return 3;
        return 0;
    endfunction

    // Cycles per degree for a given mode and window state
    function automatic int step_period(input int mode, input int nws);
        if (mode == 1 || mode == 2) return nws ? 8 : 16;
        if (mode == 3) return 32 / 4;
        return 32;
    endfunction

    function automatic int next_temp(input int mode, input int t);
        if (mode == 1) return (t + 1 > 50) ? 50 : t + 1;
        if (mode == 2) return (t - 1 < 0) ? 0 : t - 1;
        if (t < 10) return t + 1;
        if (t > 10) return t - 1;
        return t;
    endfunction

    task automatic model_reset();
        m_rt = 20; m_mode = 0; m_prev_nws = 1; m_el = 0; m_vld = 0;
    endtask

    task automatic model_clock();
        int nm, nt;
        if (!EN) begin
            m_vld = 0;
            return;
        end
        nm = want_mode(int'(LED), int'(nWS));
        m_vld = 0;
        if (nm != m_mode || int'(nWS) != m_prev_nws) begin
            m_el = 0;
        end else begin
            m_el++;
            if (m_el == step_period(m_mode, int'(nWS))) begin
                m_el = 0;
                nt = next_temp(m_mode, m_rt);
                m_vld = (nt != m_rt);
                m_rt = nt;
            end
        end
        m_mode = nm;
        m_prev_nws = int'(nWS);
    endtask

    // Advance n clocks, checking all outputs against the model after each edge
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_clock();
            @(negedge clk);
            chk("rt", int'(RT), m_rt);
            chk("rt_valid", int'(RT_VALID), m_vld);
            chk("mode", int'(MODE), m_mode);
        end
    endtask

    task automatic drive(input int led, input int nws, input int en);
        LED = 2'(led); nWS = nws[0]; EN = en[0];
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1, 1);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rt", int'(RT), 20);
        chk("reset_valid", int'(RT_VALID), 0);
        chk("reset_mode", int'(MODE), 0);
        rst = 1'b0;

        // Idle drift from 20 toward 10, window closed
        run(31);
        chk("drift_hold", int'(RT), 20);
        run(1);
        chk("drift_first", int'(RT), 19);
        chk("drift_pulse", int'(RT_VALID), 1);
        run(300);
        chk("drift_settle", int'(RT), 10);

        // Heat: first step P+1 edges after the command, then saturate at 50
        drive(1, 1, 1);
        run(8);
        chk("heat_before", int'(RT), 10);
        run(1);
        chk("heat_first", int'(RT), 11);
        run(400);
        chk("heat_sat", int'(RT), 50);
        chk("heat_sat_novalid", int'(RT_VALID), 0);

        // Cool with window open: 16-cycle steps down to 0
        drive(2, 0, 1);
        run(16);
        chk("cool_before", int'(RT), 50);
        run(1);
        chk("cool_first", int'(RT), 49);
        run(900);
        chk("cool_sat", int'(RT), 0);

        // Leak toward 10, then close window mid-count
        drive(0, 0, 1);
        run(8);
        chk("leak_before", int'(RT), 0);
        run(1);
        chk("leak_first", int'(RT), 1);
        run(4);
        drive(0, 1, 1);
        run(32);
        chk("close_restart", int'(RT), 1);
        run(1);
        chk("close_step", int'(RT), 2);

        // LED=11 behaves as off; freeze with EN=0 mid-period
        drive(3, 1, 1);
        run(10);
        drive(3, 1, 0);
        run(100);
        chk("freeze_rt", int'(RT), 2);
        chk("freeze_mode", int'(MODE), 0);
        drive(3, 1, 1);
        run(22);
        chk("resume_step", int'(RT), 3);

        // Asynchronous reset part way through a heat period
        drive(1, 1, 1);
        run(12);
        #2 rst = 1'b1;
        #1;
        chk("async_rt", int'(RT), 20);
        chk("async_mode", int'(MODE), 0);
        chk("async_valid", int'(RT_VALID), 0);
        model_reset();
        @(negedge clk);
        drive(0, 1, 1);
        rst = 1'b0;

        // Random command segments
        for (int s = 0; s < 80; s++) begin
            drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7) != 0));
            run(int'($urandom_range(1, 60)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
